instruction_fetch: RTL and testbench

//  Producer side of the iIR/iPC interface consumed by the ALU instruction units (U/I/R/...).

---
 rtl/instruction_fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: widths, reset PC,
// NOP encoding and fetch FSM state encodings.
package instruction_fetch_pkg;

    localparam int          IF_PC_W     = 8;
    localparam logic [7:0]  IF_RESET_PC = 8'h00;
    localparam int          IF_DEPTH    = 2;
    localparam logic [31:0] IF_NOP      = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_DROP = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// Small {PC, IR} FIFO. Entry 0 is the head and drives the consumer directly, so
// the outputs keep their last value once the buffer drains or is flushed.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = IF_RESET_PC,
    parameter int              DEPTH    = IF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [PC_W-1:0]              push_pc,
    input  logic [31:0]                  push_ir,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [PC_W-1:0]              head_pc,
    output logic [31:0]                  head_ir
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [PC_W-1:0]  pc_d [DEPTH];
    logic [PC_W-1:0]  up_pc [DEPTH];
    logic [31:0]      ir_q [DEPTH];
    logic [31:0]      ir_d [DEPTH];
    logic [31:0]      up_ir [DEPTH];
    logic [CNT_W-1:0] count_q, count_d, wr_idx;
    logic             pop_eff, push_eff;

    // Value each entry takes when the queue advances by one on a pop.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
        if (gi < DEPTH - 1) begin : g_mid
            assign up_pc[gi] = pc_q[gi+1];
            assign up_ir[gi] = ir_q[gi+1];
        end else begin : g_last
            assign up_pc[gi] = pc_q[gi];
            assign up_ir[gi] = ir_q[gi];
        end
    end

    always_comb begin
        pop_eff  = pop && (count_q != '0);
        push_eff = push && (pop_eff || (count_q != CNT_W'(DEPTH)));
        wr_idx   = count_q - (pop_eff ? CNT_W'(1) : CNT_W'(0));
        count_d  = flush ? '0 : wr_idx + (push_eff ? CNT_W'(1) : CNT_W'(0));
        for (int i = 0; i < DEPTH; i++) begin
            pc_d[i] = pc_q[i];
            ir_d[i] = ir_q[i];
            // Only shift live entries, so a lone head stays visible after it is taken.
            if (!flush && pop_eff && (CNT_W'(i + 1) < count_q)) begin
                pc_d[i] = up_pc[i];
                ir_d[i] = up_ir[i];
            end
            if (!flush && push_eff && (CNT_W'(i) == wr_idx)) begin
                pc_d[i] = push_pc;
                ir_d[i] = push_ir;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= RESET_PC;
                ir_q[i] <= IF_NOP;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= pc_d[i];
                ir_q[i] <= ir_d[i];
            end
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_pc    = pc_q[0];
    assign head_ir    = ir_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: one-outstanding memory request FSM, fetch PC,
// redirect handling and a small output buffer feeding the execute units.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = IF_RESET_PC,
    parameter int              DEPTH    = IF_DEPTH
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iREDIRECT,
    input  logic [PC_W-1:0] iREDIRECT_PC,
    output logic            oIMEM_REQ,
    output logic [PC_W-1:0] oIMEM_ADDR,
    input  logic            iIMEM_ACK,
    input  logic [31:0]     iIMEM_DATA,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [31:0]     oIR,
    output logic [PC_W-1:0] oPC
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  req_addr_q, req_addr_d;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    // A pop in the redirect cycle is meaningless: the flush wins.
    assign pop = iREADY && !iREDIRECT;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Issuing only with a free slot reserves room for the returning word.
                if (!iREDIRECT && (count < CNT_W'(DEPTH))) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (iIMEM_ACK) begin
                    state_d    = ST_IDLE;
                    push       = !iREDIRECT;
                    fetch_pc_d = fetch_pc_q + PC_W'(4);
                end else if (iREDIRECT) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (iIMEM_ACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (iREDIRECT) begin
            fetch_pc_d = iREDIRECT_PC & ~PC_W'(3);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // The request address is latched separately so it stays put through DROP.
    assign oIMEM_REQ  = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign oIMEM_ADDR = req_addr_q;

    fetch_buffer #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) u_buffer (
        .clk        (iCLK),
        .rst        (iRST),
        .push       (push),
        .push_pc    (req_addr_q),
        .push_ir    (iIMEM_DATA),
        .pop        (pop),
        .flush      (iREDIRECT),
        .count      (count),
        .head_valid (oVALID),
        .head_pc    (oPC),
        .head_ir    (oIR)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory model answers requests, the
// expected stream after each reset/redirect is target, target+4, ... with addr-derived words.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] ir;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST, iREDIRECT, iREADY, oIMEM_REQ, oVALID, iIMEM_ACK;
    logic [7:0]  iREDIRECT_PC, oIMEM_ADDR, oPC;
    logic [31:0] iIMEM_DATA, oIR;
    logic        mem_ack = 1'b0, inj_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;

    logic        w_rst, w_ack = 1'b0, w_req, w_valid;
    logic [7:0]  w_addr, w_pc;
    logic [31:0] w_data = 32'h0, w_ir;

    int   checks = 0, errors = 0, n_acc = 0, w_seen = 0;
    int   mem_lat = 1, mem_wait = 0;
    bit   mem_busy = 0, w_busy = 0;
    logic [7:0] mem_addr_l = 8'h0, w_addr_l = 8'h0;
    exp_t exp_q[$], w_exp[$];
    exp_t mon_e, w_e;

    always #5 iCLK = ~iCLK;

    assign iIMEM_ACK  = mem_ack | inj_ack;
    assign iIMEM_DATA = inj_ack ? 32'hDEAD_BEEF : mem_data;

    instruction_fetch dut (
        .iCLK(iCLK), .iRST(iRST), .iREDIRECT(iREDIRECT), .iREDIRECT_PC(iREDIRECT_PC),
        .oIMEM_REQ(oIMEM_REQ), .oIMEM_ADDR(oIMEM_ADDR), .iIMEM_ACK(iIMEM_ACK),
        .iIMEM_DATA(iIMEM_DATA), .oVALID(oVALID), .iREADY(iREADY), .oIR(oIR), .oPC(oPC)
    );

    instruction_fetch #(.RESET_PC(8'hF8)) dut_w (
        .iCLK(iCLK), .iRST(w_rst), .iREDIRECT(1'b0), .iREDIRECT_PC(8'h00),
        .oIMEM_REQ(w_req), .oIMEM_ADDR(w_addr), .iIMEM_ACK(w_ack),
        .iIMEM_DATA(w_data), .oVALID(w_valid), .iREADY(1'b1), .oIR(w_ir), .oPC(w_pc)
    );

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {a ^ 8'h3C, 8'hA5, ~a, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream after a reset or redirect: consecutive words from the target.
    task automatic load_seq(input logic [7:0] t);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < 256; k++) begin
            e.pc = t + 8'(4 * k);
            e.ir = word_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // Memory model: acks mem_lat cycles after the request appears, checks address stability.
    always @(posedge iCLK) begin
        #1;
        mem_ack = 1'b0;
        if (iRST) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            chk("addr_stable", {oIMEM_REQ, oIMEM_ADDR}, {1'b1, mem_addr_l});
            mem_wait--;
            if (mem_wait == 0) begin
                mem_ack  = 1'b1;
                mem_data = word_of(mem_addr_l);
                mem_busy = 0;
            end
        end else if (oIMEM_REQ) begin
            mem_busy   = 1;
            mem_wait   = mem_lat;
            mem_addr_l = oIMEM_ADDR;
        end
    end

    always @(posedge iCLK) begin
        #1;
        w_ack = 1'b0;
        if (w_rst) begin
            w_busy = 0;
        end else if (w_busy) begin
            w_ack  = 1'b1;
            w_data = word_of(w_addr_l);
            w_busy = 0;
        end else if (w_req) begin
            w_busy   = 1;
            w_addr_l = w_addr;
        end
    end

    // Monitor: samples just before the rising edge where a handshake will complete.
    always @(negedge iCLK) begin
        #3;
        if (!iRST && oVALID && iREADY && !iREDIRECT) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h, required no output", oPC);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", {24'h0, oPC}, {24'h0, mon_e.pc});
                chk("out_ir", oIR, mon_e.ir);
            end
        end
        if (!w_rst && w_valid && (w_exp.size() > 0)) begin
            w_e = w_exp.pop_front();
            chk("wrap_pc", {24'h0, w_pc}, {24'h0, w_e.pc});
            chk("wrap_ir", w_ir, w_e.ir);
            w_seen++;
        end
    end

    initial begin
        int   acc0, k;
        bit   was;
        logic [7:0] t;
        exp_t e;

        iRST = 1'b1; w_rst = 1'b1; iREDIRECT = 1'b0; iREDIRECT_PC = 8'h00; iREADY = 1'b0;
        cyc(2);
        chk("rst_valid", oVALID, 0);
        chk("rst_ir", oIR, NOP);
        chk("rst_pc", oPC, 8'h00);
        chk("rst_req", oIMEM_REQ, 0);
        chk("rst_addr", oIMEM_ADDR, 8'h00);
        chk("rst_w_pc", w_pc, 8'hF8);

        load_seq(8'h00);
        foreach (w_exp[i]) w_exp.delete(i);
        for (int i = 0; i < 4; i++) begin
            e.pc = 8'hF8 + 8'(4 * i);
            e.ir = word_of(e.pc);
            w_exp.push_back(e);
        end
        iRST = 1'b0; w_rst = 1'b0;

        // Streaming with a 1-cycle memory and an always-ready consumer.
        iREADY = 1'b1; mem_lat = 1; acc0 = n_acc;
        cyc(20);
        chk("stream_accepts", (n_acc - acc0) >= 3, 1);

        // Back-pressure: buffer fills to two and fetching stops.
        iREADY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (i >= 6) chk("stall_no_req", oIMEM_REQ, 0);
        end
        chk("stall_valid", oVALID, 1);
        iREADY = 1'b1;
        cyc(1);
        chk("stall_second_entry", oVALID, 1);
        cyc(1);
        chk("stall_drained", oVALID, 0);
        cyc(12);

        // Redirect while a slow request is outstanding and one entry is buffered.
        iREADY = 1'b0; mem_lat = 3;
        k = 0;
        while (!(oIMEM_REQ && oVALID) && k < 30) begin cyc(1); k++; end
        chk("redir_setup_timeout", k < 30, 1);
        iREDIRECT = 1'b1; iREDIRECT_PC = 8'h41; load_seq(8'h40);
        cyc(1);
        iREDIRECT = 1'b0;
        chk("redir_flush", oVALID, 0);
        iREADY = 1'b1; acc0 = n_acc;
        cyc(20);
        chk("redir_progress", (n_acc - acc0) >= 1, 1);

        // Redirect in the same cycle as the ack: the word is lost, next fetch at target.
        mem_lat = 2;
        k = 0;
        while (k < 30) begin
            @(negedge iCLK);
            if (iIMEM_ACK) break;
            k++;
        end
        chk("ack_wait_timeout", k < 30, 1);
        iREDIRECT = 1'b1; iREDIRECT_PC = 8'h80; load_seq(8'h80);
        cyc(1);
        iREDIRECT = 1'b0;
        chk("ack_redir_flush", oVALID, 0);
        k = 0;
        while (!oIMEM_REQ && k < 10) begin cyc(1); k++; end
        chk("ack_redir_addr", {k < 10, oIMEM_ADDR}, {1'b1, 8'h80});
        cyc(15);

        // Randomized traffic with occasional redirects.
        for (int n = 0; n < 400; n++) begin
            iREADY  = ($urandom_range(0, 9) < 7);
            mem_lat = $urandom_range(1, 3);
            if (!iREDIRECT && $urandom_range(0, 19) == 0) begin
                t = 8'($urandom);
                iREDIRECT = 1'b1; iREDIRECT_PC = t; load_seq(t & 8'hFC);
            end else begin
                iREDIRECT = 1'b0;
            end
            was = iREDIRECT;
            cyc(1);
            if (was) chk("rand_redir_flush", oVALID, 0);
        end
        iREDIRECT = 1'b0;

        // Reset mid-request, then a stray ack while idle.
        iREADY = 1'b1; mem_lat = 3;
        k = 0;
        while (!oIMEM_REQ && k < 20) begin cyc(1); k++; end
        chk("rst_mid_setup", k < 20, 1);
        cyc(1);
        iRST = 1'b1;
        #1;
        chk("rst_mid_valid", oVALID, 0);
        chk("rst_mid_req", oIMEM_REQ, 0);
        chk("rst_mid_ir", oIR, NOP);
        cyc(2);
        iRST = 1'b0; inj_ack = 1'b1; load_seq(8'h00);
        cyc(1);
        inj_ack = 1'b0;
        chk("post_rst_req", {oIMEM_REQ, oIMEM_ADDR}, {1'b1, 8'h00});
        acc0 = n_acc;
        cyc(30);
        chk("post_rst_accepts", (n_acc - acc0) >= 3, 1);

        chk("wrap_seen", w_seen, 4);
        chk("total_accepts", n_acc > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
